// File: rtl/hazard_ctrl_if.sv
// Hazard control bundle between the pipeline datapath and hazard_ctrl.
// master: pipeline side driving hazard inputs; slave: hazard_ctrl itself.
// Optional HAZARD_PERF_CNT_EN adds the stall/flush performance counters.
interface hazard_ctrl_if;
  logic       br_taken_e;
  logic [4:0] rs1_d;
  logic [4:0] rs2_d;
  logic [4:0] rd_e;
  logic       mem_read_e;
  logic       mdu_start_e;
  logic       mdu_done;
  logic       stall_f;
  logic       stall_d;
  logic       stall_e;
  logic       flush_d;
  logic       flush_e;
  logic       flush_m;
  logic       mdu_busy;
  logic       mdu_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;

  modport master (
    output br_taken_e, rs1_d, rs2_d, rd_e, mem_read_e, mdu_start_e, mdu_done,
    input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy, mdu_err,
    input  stall_cycles, flush_events
  );
  modport slave (
    input  br_taken_e, rs1_d, rs2_d, rd_e, mem_read_e, mdu_start_e, mdu_done,
    output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy, mdu_err,
    output stall_cycles, flush_events
  );
`else
  modport master (
    output br_taken_e, rs1_d, rs2_d, rd_e, mem_read_e, mdu_start_e, mdu_done,
    input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy, mdu_err
  );
  modport slave (
    input  br_taken_e, rs1_d, rs2_d, rd_e, mem_read_e, mdu_start_e, mdu_done,
    output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy, mdu_err
  );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush sequencer: branch flush, load-use stall, MDU wait with watchdog.
// Latency: stall/flush outputs are combinational (zero cycles) from state and inputs.
// Backpressure: holds F/D/E while the MDU is busy; watchdog forces release after MDU_TIMEOUT.
// Optional macro HAZARD_PERF_CNT_EN adds stall_cycles / flush_events counters.
module hazard_ctrl #(
  parameter int MDU_TIMEOUT = 64
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam int WD_W = $clog2(MDU_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_TIMEOUT - 1);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MDU_WAIT = 1'b1;

  logic [0:0]      state;
  logic [0:0]      state_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic            err_q;
  logic            wd_fire;
  logic            lu;
  logic            st_f, st_d, st_e, fl_d, fl_e, fl_m;
  logic            br_flush;

  assign lu = hz.mem_read_e && (hz.rd_e != 5'd0) &&
              ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

  // Decode stall/flush controls and next state from current state and hazard inputs.
  always_comb begin
    st_f      = 1'b0;
    st_d      = 1'b0;
    st_e      = 1'b0;
    fl_d      = 1'b0;
    fl_e      = 1'b0;
    fl_m      = 1'b0;
    wd_fire   = 1'b0;
    br_flush  = 1'b0;
    state_nxt = state;
    case (state)
      RUN: begin
        if (hz.br_taken_e) begin
          // D instruction is killed, so any load-use hit on it is moot.
          fl_d     = 1'b1;
          fl_e     = 1'b1;
          br_flush = 1'b1;
        end else if (hz.mdu_start_e && !hz.mdu_done) begin
          st_f      = 1'b1;
          st_d      = 1'b1;
          st_e      = 1'b1;
          fl_m      = 1'b1;
          state_nxt = MDU_WAIT;
        end else if (hz.mdu_start_e) begin
          // Single-cycle MDU op: result ready, no stall.
        end else if (lu) begin
          st_f = 1'b1;
          st_d = 1'b1;
          fl_e = 1'b1;
        end
      end
      default: begin
        if (hz.mdu_done) begin
          state_nxt = RUN;
        end else if (wd_cnt == WD_LAST) begin
          // Watchdog expiry releases the pipeline exactly like a done would.
          wd_fire   = 1'b1;
          state_nxt = RUN;
        end else begin
          st_f = 1'b1;
          st_d = 1'b1;
          st_e = 1'b1;
          fl_m = 1'b1;
        end
      end
    endcase
    if (rst) begin
      st_f     = 1'b0;
      st_d     = 1'b0;
      st_e     = 1'b0;
      fl_d     = 1'b0;
      fl_e     = 1'b0;
      fl_m     = 1'b0;
      wd_fire  = 1'b0;
      br_flush = 1'b0;
    end
  end

  // State, watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == RUN) begin
        wd_cnt <= '0;
      end else if (!hz.mdu_done) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wd_fire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign hz.stall_f  = st_f;
  assign hz.stall_d  = st_d;
  assign hz.stall_e  = st_e;
  assign hz.flush_d  = fl_d;
  assign hz.flush_e  = fl_e;
  assign hz.flush_m  = fl_m;
  assign hz.mdu_busy = (state == MDU_WAIT) && !rst;
  assign hz.mdu_err  = err_q && !rst;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  // Free-running wrap-around counters of stalled fetch cycles and branch flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (st_f) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (br_flush) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

  assign hz.stall_cycles = stall_cnt;
  assign hz.flush_events = flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: table of per-cycle vectors plus reset/watchdog sequences.
// Output vector order: {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy, mdu_err}.
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  hazard_ctrl_if hz();

  hazard_ctrl #(.MDU_TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       br;
    logic       mr;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       st;
    logic       dn;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  localparam logic [7:0] O_IDLE = 8'b00000000;
  localparam logic [7:0] O_LU   = 8'b11001000;
  localparam logic [7:0] O_BR   = 8'b00011000;
  localparam logic [7:0] O_MST  = 8'b11100100;
  localparam logic [7:0] O_MWT  = 8'b11100110;
  localparam logic [7:0] O_MDN  = 8'b00000010;

  function automatic vec_t mk(logic br, logic mr, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic st, logic dn, logic [7:0] exp);
    vec_t v;
    v.br = br; v.mr = mr; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.st = st; v.dn = dn; v.exp = exp;
    return v;
  endfunction

  task automatic drive(logic br, logic mr, logic [4:0] rs1, logic [4:0] rs2,
                       logic [4:0] rd, logic st, logic dn);
    hz.br_taken_e  = br;
    hz.mem_read_e  = mr;
    hz.rs1_d       = rs1;
    hz.rs2_d       = rs2;
    hz.rd_e        = rd;
    hz.mdu_start_e = st;
    hz.mdu_done    = dn;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [7:0] exp);
    logic [7:0] act;
    @(negedge clk);
    act = {hz.stall_f, hz.stall_d, hz.stall_e, hz.flush_d, hz.flush_e, hz.flush_m,
           hz.mdu_busy, hz.mdu_err};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Each row is one cycle; FSM state carries from row to row.
    vecs[0]  = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, O_IDLE);
    vecs[1]  = mk(0, 1, 5'd1, 5'd5, 5'd5, 0, 0, O_LU);   // load-use via rs2
    vecs[2]  = mk(0, 0, 5'd1, 5'd5, 5'd5, 0, 0, O_IDLE); // bubble next cycle
    vecs[3]  = mk(0, 1, 5'd7, 5'd2, 5'd7, 0, 0, O_LU);   // load-use via rs1
    vecs[4]  = mk(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, O_IDLE); // rd = x0 never hazards
    vecs[5]  = mk(0, 0, 5'd3, 5'd5, 5'd5, 0, 0, O_IDLE); // not a load
    vecs[6]  = mk(1, 1, 5'd3, 5'd5, 5'd5, 0, 0, O_BR);   // branch beats load-use
    vecs[7]  = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, O_BR);
    vecs[8]  = mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 1, O_IDLE); // single-cycle MDU
    vecs[9]  = mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, O_MST);  // MDU cycle 0
    vecs[10] = mk(1, 1, 5'd4, 5'd0, 5'd4, 1, 0, O_MWT);  // cycle 1: br/lu/start ignored
    vecs[11] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, O_MWT);  // cycle 2
    vecs[12] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, O_MWT);  // cycle 3
    vecs[13] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, O_MDN);  // cycle 4: done
    vecs[14] = mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, O_MST);  // back-to-back start
    vecs[15] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, O_MDN);  // done one cycle later
    vecs[16] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, O_IDLE);

    // Reset held with aggressive inputs: everything must read 0.
    rst = 1'b1;
    drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_hold%0d", i), O_IDLE);
      tick();
    end
    rst = 1'b0;
    idle();
    chk("reset_release", O_IDLE);
    tick();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].br, vecs[i].mr, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
            vecs[i].st, vecs[i].dn);
      chk($sformatf("vec%0d", i), vecs[i].exp);
      tick();
    end

    // Watchdog with MDU_TIMEOUT=8: start + 7 stalled waits, release on the 8th wait cycle.
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("wd_start", O_MST);
    tick();
    idle();
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("wd_wait%0d", k), O_MWT);
      tick();
    end
    chk("wd_release", O_MDN);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wd_err_sticky%0d", k), 8'b00000001);
      tick();
    end

    // Reset mid-wait returns to RUN and clears the sticky error.
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("mid_start", 8'b11100101);
    tick();
    idle();
    chk("mid_wait", 8'b11100111);
    tick();
    rst = 1'b1;
    chk("mid_rst", O_IDLE);
    tick();
    rst = 1'b0;
    chk("mid_after_rst", O_IDLE);
    tick();
    drive(1'b0, 1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b0);
    chk("mid_run_lu", O_LU);
    tick();
    idle();

`ifdef HAZARD_PERF_CNT_EN
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      chk($sformatf("perf_br%0d", k), O_BR);
      tick();
    end
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("perf_mst", O_MST);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("perf_wait%0d", k), O_MWT);
      tick();
    end
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    chk("perf_done", O_MDN);
    tick();
    idle();
    @(negedge clk);
    // One load-use stall happened after the mid-wait reset, before these 4 MDU stalls.
    chk32("perf_flush_events", hz.flush_events, 32'd3);
    chk32("perf_stall_cycles", hz.stall_cycles, 32'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline stall/flush sequencer for the 5-stage core. It combines the branch unit's taken signal, load-use detection and the multi-cycle MDU handshake into per-stage stall/flush controls. It tracks MDU occupancy with a small FSM and a watchdog, and sits alongside the branch unit in EX, driving the F/D/E/M pipeline registers.

## Interface
- `MDU_TIMEOUT`, default 64: max cycles spent in MDU_WAIT before forced release; legal range 2..1024.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `br_taken_e`  in  1  branch/jump resolved taken in EX (branch unit `next_pc_src`).
- `rs1_d`, `rs2_d`  in  5 each  source register indices of the instruction in D.
- `rd_e`  in  5  destination index of the instruction in E.
- `mem_read_e`  in  1  instruction in E is a load.
- `mdu_start_e`  in  1  instruction in E is a mul/div; pulse-qualified, first cycle only.
- `mdu_done`  in  1  MDU result valid this cycle.
- `stall_f`, `stall_d`, `stall_e`  out  1 each  hold the PC / IF-ID / ID-EX registers.
- `flush_d`, `flush_e`, `flush_m`  out  1 each  bubble into IF-ID / ID-EX / EX-MEM.
- `mdu_busy`  out  1  FSM is in MDU_WAIT.
- `mdu_err`  out  1  sticky watchdog-expired flag.

## Operation
- FSM states: RUN, MDU_WAIT. Reset state RUN.
- Load-use hit `lu` = `mem_read_e` & (`rd_e`≠0) & (`rd_e`==`rs1_d` | `rd_e`==`rs2_d`).
- RUN, priority high to low:
  - `br_taken_e`: `flush_d`=`flush_e`=1. All stalls 0. Load-use is ignored because the D instruction is killed.
  - `mdu_start_e` & !`mdu_done`: go to MDU_WAIT. This cycle drives `stall_f`=`stall_d`=`stall_e`=1 and `flush_m`=1.
  - `mdu_start_e` & `mdu_done` (single-cycle op): no stall, stay in RUN.
  - `lu`: `stall_f`=`stall_d`=1, `flush_e`=1, for exactly one cycle per hazard.
  - Otherwise all outputs 0.
- MDU_WAIT:
  - `stall_f`=`stall_d`=`stall_e`=1 and `flush_m`=1 every cycle.
  - `br_taken_e`, `lu` and `mdu_start_e` are ignored.
  - `mdu_done`: this cycle drives all outputs 0 (E advances); next state RUN.
  - Watchdog `wd_cnt`, width $clog2(MDU_TIMEOUT+1), clears on entry and increments each MDU_WAIT cycle without `mdu_done`.
  - When `wd_cnt`==MDU_TIMEOUT−1 and no `mdu_done`: release as if done, set `mdu_err`, go to RUN.
- `mdu_err` clears only on `rst`.
- `mdu_busy` = (state==MDU_WAIT).

## Timing
- Stall/flush outputs are combinational from the registered state and current inputs, with zero-cycle latency. This is required so `flush_d`/`flush_e` track `br_taken_e` in the same cycle.
- While `rst`=1 all outputs are forced to 0. After the reset edge: state RUN, `wd_cnt`=0, `mdu_err`=0, counters 0.
- `rst` asserted mid-MDU_WAIT returns to RUN on that edge, with no `mdu_err` update.
- MDU stall length equals the number of cycles from the start cycle to the `mdu_done` cycle. A done arriving N cycles after start yields N stall cycles.
- The watchdog bounds MDU_WAIT (including the entry cycle) to at most MDU_TIMEOUT+1 cycles.
- Back-to-back: a new `mdu_start_e` in the cycle right after release is accepted normally.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - Adds outputs `stall_cycles` [31:0], incremented every cycle `stall_f`=1.
  - Adds `flush_events` [31:0], incremented each cycle `br_taken_e` causes a flush.
  - Both counters wrap at 2^32 and reset to 0.
- Not defined: ports and logic absent; control behaviour is identical.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `br_taken_e`=1 and `mdu_start_e`=1 -> all outputs 0. After release, `mdu_busy`=0 and `mdu_err`=0.
- Load-use: `mem_read_e`=1, `rd_e`=5, `rs2_d`=5 for one cycle -> `stall_f`=`stall_d`=`flush_e`=1 that cycle only. Same with `rd_e`=0 -> no stall.
- Branch over load-use: `br_taken_e`=1 together with a load-use hit -> `flush_d`=`flush_e`=1, `stall_f`=0.
- MDU: `mdu_start_e` at cycle 0, `mdu_done` at cycle 4 -> stalls high cycles 0–3, low at 4, `mdu_busy` high cycles 1–4. `mdu_done` with start at cycle 0 -> no stall.
- Watchdog: MDU_TIMEOUT=8, start with no done -> forced release, then `mdu_err`=1 held until `rst`. A `rst` pulse mid-wait -> RUN, `mdu_err`=0.
- With `HAZARD_PERF_CNT_EN`: 3 branch flushes plus a 4-cycle MDU wait -> `flush_events`=3, `stall_cycles`=4.
